// File: rtl/sl_rx_ctrl.sv
// sl_rx_ctrl: host register-bus controller for one SL serial receiver.
// Drives the receiver config word, turns rising WRF/LEF status edges into
// FIFO entries {WLC,PEF,LEF,data}, and raises a level or pulse interrupt.
// Optional build macro: SL_RX_CTRL_ERR_CNT_EN adds an 8-bit saturating
// error counter readable in STATUS[23:16].
module sl_rx_ctrl #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CFG_RESET  = 16'h0020
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  i_bus_addr,
  input  logic        i_bus_wr,
  input  logic        i_bus_rd,
  input  logic [31:0] i_bus_wdata,
  output logic [31:0] o_bus_rdata,
  output logic        o_bus_ack,
  output logic        o_irq,
  output logic [15:0] o_rx_config,
  input  logic [15:0] i_rx_status,
  input  logic [31:0] i_rx_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      r_rdata;
  logic             r_ack;
  logic             r_irq;
  logic [15:0]      r_config;
  logic [15:0]      r_prevStatus;
  logic             r_ovf;
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic [34:0]      r_mem [FIFO_DEPTH];

  logic        w_accept;
  logic        w_isWrite;
  logic        w_isRead;
  logic        w_selCfg;
  logic        w_selDataWr;
  logic        w_selDataR;
  logic        w_selStat;
  logic        w_cfgWrite;
  logic        w_statWrite;
  logic        w_dataRead;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wrfEdge;
  logic        w_lefEdge;
  logic        w_evt;
  logic        w_push;
  logic        w_drop;
  logic [34:0] w_evtEntry;
  logic [34:0] w_head;
  logic [2:0]  w_headFlags;
  logic [7:0]  w_count8;
  logic [7:0]  w_errField;
  logic [31:0] w_statusWord;
  logic [31:0] w_rdataNext;
  logic        w_unused;

  assign w_unused = ^{i_bus_wdata, i_rx_status};

  // Bus request decode: a write wins when rd and wr are both high, and
  // only an exact one-hot address selects a register.
  assign w_accept    = (i_bus_rd | i_bus_wr) & ~r_ack;
  assign w_isWrite   = i_bus_wr;
  assign w_isRead    = i_bus_rd & ~i_bus_wr;
  assign w_selCfg    = (i_bus_addr == 4'b0001);
  assign w_selDataWr = (i_bus_addr == 4'b0010);
  assign w_selDataR  = (i_bus_addr == 4'b0100);
  assign w_selStat   = (i_bus_addr == 4'b1000);
  assign w_cfgWrite  = w_accept & w_isWrite & w_selCfg;
  assign w_statWrite = w_accept & w_isWrite & w_selStat;
  assign w_dataRead  = w_accept & w_isRead & w_selDataR;

  // FIFO state and the push/pop/drop decisions for this cycle.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop   = w_dataRead & ~w_empty;

  assign w_wrfEdge  = i_rx_status[3] & ~r_prevStatus[3];
  assign w_lefEdge  = i_rx_status[5] & ~r_prevStatus[5];
  assign w_evt      = w_wrfEdge | w_lefEdge;
  assign w_evtEntry = {i_rx_status[0], i_rx_status[4], i_rx_status[5],
                       (w_lefEdge ? 32'h0 : i_rx_data)};
  assign w_push     = w_evt & (~w_full | w_pop) & ~w_cfgWrite;
  assign w_drop     = w_evt & w_full & ~w_pop & ~w_cfgWrite;

  assign w_head      = r_mem[r_rdPtr];
  assign w_headFlags = w_empty ? 3'b000 : w_head[34:32];
  assign w_count8    = {{(8-CNT_W){1'b0}}, r_count};

`ifdef SL_RX_CTRL_ERR_CNT_EN
  logic [7:0] r_errCnt;
  logic       w_errEvt;

  assign w_errEvt   = w_evt & (i_rx_status[0] | i_rx_status[4] | i_rx_status[5]);
  assign w_errField = r_errCnt;

  // Saturating error counter; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_errCnt <= 8'h00;
    end else if (w_statWrite && i_bus_wdata[31]) begin
      r_errCnt <= 8'h00;
    end else if (w_errEvt && (r_errCnt != 8'hFF)) begin
      r_errCnt <= r_errCnt + 8'h01;
    end
  end
`else
  assign w_errField = 8'h00;
`endif

  // Assemble the STATUS word and select the read data for an accepted read.
  always_comb begin
    w_statusWord = {8'h00, w_errField, w_count8, r_irq, i_rx_status[1],
                    r_ovf, w_full, ~w_empty, w_headFlags};
    w_rdataNext  = 32'h0;
    if (w_isRead) begin
      if (w_selCfg) begin
        w_rdataNext = {16'h0, r_config};
      end else if (w_selDataR) begin
        w_rdataNext = w_empty ? 32'h0 : w_head[31:0];
      end else if (w_selStat) begin
        w_rdataNext = w_statusWord;
      end else if (w_selDataWr) begin
        w_rdataNext = 32'h0;
      end
    end
  end

  // One-cycle acknowledge with read data registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_ack   <= w_accept;
      r_rdata <= w_accept ? w_rdataNext : 32'h0;
    end
  end

  // Config register and the status history used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_config     <= CFG_RESET;
      r_prevStatus <= 16'h0;
    end else begin
      r_prevStatus <= i_rx_status;
      if (w_cfgWrite) begin
        r_config <= i_bus_wdata[15:0];
      end
    end
  end

  // FIFO pointers and occupancy; a config write flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (w_cfgWrite) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the count gates every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= w_evtEntry;
    end
  end

  // Sticky overflow flag: a drop beats a W1C in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_cfgWrite) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_statWrite && i_bus_wdata[5]) begin
      r_ovf <= 1'b0;
    end
  end

  // Interrupt: level of (not empty | OVF), or a pulse per push / new OVF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (r_config[8]) begin
      r_irq <= w_push | (w_drop & ~r_ovf);
    end else begin
      r_irq <= ~w_empty | r_ovf;
    end
  end

  assign o_bus_rdata = r_rdata;
  assign o_bus_ack   = r_ack;
  assign o_irq       = r_irq;
  assign o_rx_config = r_config;

endmodule

// File: doc/sl_rx_ctrl.md
Name: sl_rx_ctrl

Overview:
- Register-bus controller for the SL serial receiver.
- Drives the receiver's 16-bit config word and watches its status/data outputs for completion events.
- Buffers received words and error reports in a small FIFO, and raises an interrupt to the host.
- Sits between the host bus (one-hot register select) and one SL receiver instance.

Parameters:
- FIFO_DEPTH, 4: entries in the receive FIFO; power of 2, range 2..16.
- CFG_RESET, 16'h0020: reset value driven on rx_config.

Ports:
- clk  in  1  system clock, 16 MHz.
- rst_n  in  1  asynchronous active-low reset.
- bus_addr  in  4  one-hot register select: 0001 CONFIG, 0010 DATA_WR, 0100 DATA_R, 1000 STATUS.
- bus_wr  in  1  write request.
- bus_rd  in  1  read request.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data; valid while bus_ack is high.
- bus_ack  out  1  one-cycle acknowledge.
- irq  out  1  interrupt to host.
- rx_config  out  16  receiver config. Bit 0 parity check enable, bits 6:1 bit quantity, bit 7 mode, bit 8 IRQM.
- rx_status  in  16  receiver status. Bit 0 WLC (length error), bit 1 WRP (receiving), bit 3 WRF (word done), bit 4 PEF (parity error), bit 5 LEF (level error).
- rx_data  in  32  last received word.

Behaviour:
- Reset values: rx_config=CFG_RESET, bus_rdata=0, bus_ack=0, irq=0. FIFO empty, OVF=0, sampled previous status=0.
- Event detect:
  - prev_status is a register copy of rx_status, updated every cycle.
  - evt = (rx_status[3] & ~prev[3]) | (rx_status[5] & ~prev[5]).
  - On evt, push entry {WLC,PEF,LEF, rx_data} sampled in that same cycle. A LEF event stores data=0.
- FIFO:
  - Circular buffer with wrapping read/write pointers and count 0..FIFO_DEPTH.
  - Push while full (and no pop the same cycle): entry dropped, OVF set (sticky).
  - Push and pop in the same cycle: both take effect and count is unchanged. This holds when full, in which case the push is accepted and OVF is not set.
  - Pop while empty: no pointer change.
- Bus handshake:
  - A request is accepted when (bus_rd|bus_wr) & ~bus_ack.
  - bus_ack rises the next cycle for exactly one cycle, with bus_rdata registered alongside it.
  - A request held high is therefore acked every second cycle; the master drops the request after ack.
  - bus_rd and bus_wr both high: treated as a write.
  - Zero or multiple bits set in bus_addr: acked, rdata=0, no side effect.
- CONFIG:
  - Write: rx_config <= wdata[15:0], FIFO flushed, OVF cleared.
  - Read: returns {16'h0, rx_config}.
- DATA_R:
  - Read: returns head data and pops it.
  - Read while empty: returns 0.
  - Write: ignored.
- DATA_WR: reserved for the transmitter path. Write ignored, read returns 0.
- STATUS read layout:
  - [2:0] head entry {WLC,PEF,LEF}, 0 when empty.
  - [3] not empty. [4] full. [5] OVF. [6] rx_status WRP. [7] irq.
  - [15:8] count. [31:16] 0 (see optional feature).
- STATUS write: W1C; wdata[5] clears OVF. If OVF set and cleared in the same cycle, set wins.
- IRQ:
  - rx_config[8]=0: irq = registered (not empty | OVF), a level output.
  - rx_config[8]=1: irq = one-cycle pulse the cycle after each accepted push or each new OVF.
- Reset asserted mid-operation: all state returns to reset values immediately; a pending ack is lost.

Optional Feature:
- Macro: SL_RX_CTRL_ERR_CNT_EN.
- Defined:
  - 8-bit saturating error counter, incremented on each event with WLC|PEF|LEF set. Counts are taken at event time, including dropped events.
  - Counter is readable in STATUS[23:16].
  - STATUS write with wdata[31]=1 clears it; increment and clear in the same cycle gives 0.
  - Reset value 0.
- Not defined: STATUS[23:16] reads 0, no counter logic.

Test Plan:
- Reset, then read CONFIG -> rdata=32'h0000_0020, ack one cycle later; read STATUS -> 0; irq=0.
- WRF rising edge with rx_data=32'h1234_5678, status errors 0 -> STATUS count=1, bit3=1, irq=1 (IRQM=0). Read DATA_R -> 32'h1234_5678. Next STATUS read -> count 0, irq falls.
- Five WRF events with FIFO_DEPTH=4 -> count=4, full=1, OVF=1. Pops return the first four words in order. STATUS write 32'h20 -> OVF=0.
- LEF event, then WRF with PEF=1 -> STATUS[2:0]=001 then, after a pop, 010. With SL_RX_CTRL_ERR_CNT_EN, STATUS[23:16]=2.
- FIFO full, DATA_R read accepted in the same cycle as a WRF event -> count stays 4, OVF stays 0, newest word is retained.
- Write CONFIG 32'h0000_0141 with 2 entries queued -> rx_config=16'h0141, count=0. Subsequent event gives a 1-cycle irq pulse.
